// File: rtl/rcpu_io_pkg.sv
// rcpu_io_pkg: shared constants and types for the RCPU IO/UART block.
//   IO_DATA / IO_STATUS / IO_LED : IO register addresses
//   uart_state_e                 : state encoding shared by the TX and RX FSMs
//   ST_*                         : bit positions inside the STATUS register
package rcpu_io_pkg;

  localparam logic [15:0] IO_DATA   = 16'h0000;
  localparam logic [15:0] IO_STATUS = 16'h0001;
  localparam logic [15:0] IO_LED    = 16'h0002;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_state_e;

  localparam int unsigned ST_TX_EMPTY    = 0;
  localparam int unsigned ST_RX_NONEMPTY = 1;
  localparam int unsigned ST_TX_FULL     = 2;
  localparam int unsigned ST_RX_OVERRUN  = 3;

endpackage

// File: rtl/rcpu_io_fifo.sv
// rcpu_io_fifo: 8-bit synchronous FIFO, DEPTH entries (power of two).
//   clk, resetq        : clock, async active-high reset (empties the FIFO)
//   push, push_data    : write request; accepted when not full or when popping
//   pop                : read request; ignored when empty
//   pop_data_c         : head entry (combinational, valid while !empty)
//   full, empty        : registered occupancy flags
module rcpu_io_fifo #(
  parameter int unsigned DEPTH = 8
) (
  input  logic       clk,
  input  logic       resetq,
  input  logic       push,
  input  logic [7:0] push_data,
  input  logic       pop,
  output logic [7:0] pop_data_c,
  output logic       full,
  output logic       empty
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count, count_n;
  logic          do_push_c, do_pop_c;

  // A push into a full FIFO still succeeds if an entry leaves in the same cycle.
  assign do_pop_c  = pop && !empty;
  assign do_push_c = push && (!full || do_pop_c);
  assign pop_data_c = mem[rd_ptr];

  // Occupancy next-state
  always_comb begin
    count_n = count;
    if (do_push_c && !do_pop_c)      count_n = count + 1'b1;
    else if (!do_push_c && do_pop_c) count_n = count - 1'b1;
  end

  // Pointers wrap naturally at AW bits
  always_ff @(posedge clk or posedge resetq) begin
    if (resetq) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      if (do_push_c) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop_c)  rd_ptr <= rd_ptr + 1'b1;
      count <= count_n;
      full  <= (count_n == FULL_CNT);
      empty <= (count_n == '0);
    end
  end

  // Storage
  always_ff @(posedge clk) begin
    if (do_push_c) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/rcpu_io_uart.sv
// rcpu_io_uart: CPU IO slave with UART (TX/RX FIFOs) and an LED register.
//   clk, resetq                  : clock, async active-high reset
//   io_read_enable/write_enable  : one-cycle CPU access strobes
//   io_address, io_write_data    : access address and write data
//   io_read_data                 : registered read data, held until next read
//   uart_tx / uart_rx            : serial out (idle high) / async serial in
//   leds                         : LED register output
module rcpu_io_uart
  import rcpu_io_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 104,
  parameter int unsigned FIFO_DEPTH   = 8
) (
  input  logic        clk,
  input  logic        resetq,
  input  logic        io_read_enable,
  input  logic        io_write_enable,
  input  logic [15:0] io_address,
  input  logic [15:0] io_write_data,
  output logic [15:0] io_read_data,
  output logic        uart_tx,
  input  logic        uart_rx,
  output logic [7:0]  leds
);

  localparam logic [15:0] BIT_END  = 16'(CLKS_PER_BIT - 1);
  localparam logic [15:0] HALF_END = 16'(CLKS_PER_BIT / 2 - 1);

  logic       tx_fifo_full, tx_fifo_empty, rx_fifo_full, rx_fifo_empty;
  logic [7:0] tx_fifo_dout_c, rx_fifo_dout_c;
  logic       tx_push_c, tx_pop_c, rx_push_c, rx_pop_c;
  logic       tx_empty_c, rx_overrun;
  logic [15:0] status_c, rd_mux_c;
  logic       unused_c;

  uart_state_e tx_state, tx_state_n, rx_state, rx_state_n;
  logic [15:0] tx_cnt, tx_cnt_n, rx_cnt, rx_cnt_n;
  logic [2:0]  tx_bit, tx_bit_n, rx_bit, rx_bit_n;
  logic [7:0]  tx_shift, tx_shift_n, rx_shift, rx_shift_n;
  logic        tx_line_n;
  logic        rx_s1, rx_s2, rx_prev;

  assign unused_c  = ^io_write_data[15:8];
  assign tx_push_c = io_write_enable && (io_address == IO_DATA);
  assign rx_pop_c  = io_read_enable && (io_address == IO_DATA);
  assign tx_empty_c = tx_fifo_empty && (tx_state == IDLE);

  rcpu_io_fifo #(.DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .clk(clk), .resetq(resetq), .push(tx_push_c), .push_data(io_write_data[7:0]),
    .pop(tx_pop_c), .pop_data_c(tx_fifo_dout_c), .full(tx_fifo_full), .empty(tx_fifo_empty)
  );

  rcpu_io_fifo #(.DEPTH(FIFO_DEPTH)) u_rx_fifo (
    .clk(clk), .resetq(resetq), .push(rx_push_c), .push_data(rx_shift),
    .pop(rx_pop_c), .pop_data_c(rx_fifo_dout_c), .full(rx_fifo_full), .empty(rx_fifo_empty)
  );

  // Read mux built from current (pre-write) state
  always_comb begin
    status_c = '0;
    status_c[ST_TX_EMPTY]    = tx_empty_c;
    status_c[ST_RX_NONEMPTY] = !rx_fifo_empty;
    status_c[ST_TX_FULL]     = tx_fifo_full;
    status_c[ST_RX_OVERRUN]  = rx_overrun;
    rd_mux_c = '0;
    case (io_address)
      IO_DATA:   rd_mux_c = rx_fifo_empty ? 16'h0000 : {8'h01, rx_fifo_dout_c};
      IO_STATUS: rd_mux_c = status_c;
      IO_LED:    rd_mux_c = {8'h00, leds};
      default:   rd_mux_c = '0;
    endcase
  end

  // CPU-visible registers
  always_ff @(posedge clk or posedge resetq) begin
    if (resetq) begin
      io_read_data <= '0;
      leds         <= '0;
      rx_overrun   <= 1'b0;
    end else begin
      if (io_read_enable) io_read_data <= rd_mux_c;
      if (io_write_enable && (io_address == IO_LED)) leds <= io_write_data[7:0];
      // A full RX FIFO can only accept the byte if the CPU pops in the same cycle
      if (rx_push_c && rx_fifo_full && !rx_pop_c)
        rx_overrun <= 1'b1;
      else if (io_write_enable && (io_address == IO_STATUS) && io_write_data[0])
        rx_overrun <= 1'b0;
    end
  end

  // TX state register; uart_tx is the registered line value
  always_ff @(posedge clk or posedge resetq) begin
    if (resetq) begin
      tx_state <= IDLE;
      tx_cnt   <= '0;
      tx_bit   <= '0;
      tx_shift <= '0;
      uart_tx  <= 1'b1;
    end else begin
      tx_state <= tx_state_n;
      tx_cnt   <= tx_cnt_n;
      tx_bit   <= tx_bit_n;
      tx_shift <= tx_shift_n;
      uart_tx  <= tx_line_n;
    end
  end

  // TX next state; STOP reloads directly so consecutive frames have no idle gap
  always_comb begin
    tx_state_n = tx_state;
    tx_cnt_n   = tx_cnt;
    tx_bit_n   = tx_bit;
    tx_shift_n = tx_shift;
    tx_line_n  = 1'b1;
    tx_pop_c   = 1'b0;
    case (tx_state)
      IDLE: begin
        if (!tx_fifo_empty) begin
          tx_pop_c   = 1'b1;
          tx_shift_n = tx_fifo_dout_c;
          tx_cnt_n   = '0;
          tx_state_n = START;
          tx_line_n  = 1'b0;
        end
      end
      START: begin
        tx_line_n = 1'b0;
        if (tx_cnt == BIT_END) begin
          tx_cnt_n   = '0;
          tx_bit_n   = '0;
          tx_state_n = DATA;
          tx_line_n  = tx_shift[0];
        end else tx_cnt_n = tx_cnt + 1'b1;
      end
      DATA: begin
        tx_line_n = tx_shift[0];
        if (tx_cnt == BIT_END) begin
          tx_cnt_n   = '0;
          tx_shift_n = {1'b0, tx_shift[7:1]};
          if (tx_bit == 3'd7) begin
            tx_state_n = STOP;
            tx_line_n  = 1'b1;
          end else begin
            tx_bit_n  = tx_bit + 1'b1;
            tx_line_n = tx_shift[1];
          end
        end else tx_cnt_n = tx_cnt + 1'b1;
      end
      STOP: begin
        if (tx_cnt == BIT_END) begin
          tx_cnt_n = '0;
          if (!tx_fifo_empty) begin
            tx_pop_c   = 1'b1;
            tx_shift_n = tx_fifo_dout_c;
            tx_state_n = START;
            tx_line_n  = 1'b0;
          end else tx_state_n = IDLE;
        end else tx_cnt_n = tx_cnt + 1'b1;
      end
      default: tx_state_n = IDLE;
    endcase
  end

  // RX synchronizer, edge history and state register
  always_ff @(posedge clk or posedge resetq) begin
    if (resetq) begin
      rx_s1    <= 1'b1;
      rx_s2    <= 1'b1;
      rx_prev  <= 1'b1;
      rx_state <= IDLE;
      rx_cnt   <= '0;
      rx_bit   <= '0;
      rx_shift <= '0;
    end else begin
      rx_s1    <= uart_rx;
      rx_s2    <= rx_s1;
      rx_prev  <= rx_s2;
      rx_state <= rx_state_n;
      rx_cnt   <= rx_cnt_n;
      rx_bit   <= rx_bit_n;
      rx_shift <= rx_shift_n;
    end
  end

  // RX next state; all samples taken at mid-bit relative to the start edge
  always_comb begin
    rx_state_n = rx_state;
    rx_cnt_n   = rx_cnt;
    rx_bit_n   = rx_bit;
    rx_shift_n = rx_shift;
    rx_push_c  = 1'b0;
    case (rx_state)
      IDLE: begin
        if (rx_prev && !rx_s2) begin
          rx_cnt_n   = '0;
          rx_state_n = START;
        end
      end
      START: begin
        if (rx_cnt == HALF_END) begin
          rx_cnt_n   = '0;
          rx_bit_n   = '0;
          rx_state_n = rx_s2 ? IDLE : DATA;
        end else rx_cnt_n = rx_cnt + 1'b1;
      end
      DATA: begin
        if (rx_cnt == BIT_END) begin
          rx_cnt_n   = '0;
          rx_shift_n = {rx_s2, rx_shift[7:1]};
          if (rx_bit == 3'd7) rx_state_n = STOP;
          else                rx_bit_n   = rx_bit + 1'b1;
        end else rx_cnt_n = rx_cnt + 1'b1;
      end
      STOP: begin
        if (rx_cnt == BIT_END) begin
          rx_cnt_n   = '0;
          rx_push_c  = rx_s2;
          rx_state_n = IDLE;
        end else rx_cnt_n = rx_cnt + 1'b1;
      end
      default: rx_state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_rcpu_io_uart.sv
// tb_rcpu_io_uart: directed + randomized bench for rcpu_io_uart (CLKS_PER_BIT=4).
// A passive line monitor decodes uart_tx into bytes; a queue model tracks RX data.
module tb_rcpu_io_uart;

  localparam int CPB   = 4;
  localparam int DEPTH = 8;

  logic        clk = 1'b0;
  logic        resetq = 1'b1;
  logic        io_read_enable = 1'b0;
  logic        io_write_enable = 1'b0;
  logic [15:0] io_address = '0;
  logic [15:0] io_write_data = '0;
  logic [15:0] io_read_data;
  logic        uart_tx;
  logic        uart_rx = 1'b1;
  logic [7:0]  leds;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int mon_bad  = 0;

  logic [7:0] tx_seen[$];
  int         tx_start_cyc[$];
  logic [7:0] tx_exp[$];
  logic [7:0] rx_model[$];
  bit         rx_ovr_model = 0;

  rcpu_io_uart #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .resetq(resetq),
    .io_read_enable(io_read_enable), .io_write_enable(io_write_enable),
    .io_address(io_address), .io_write_data(io_write_data),
    .io_read_data(io_read_data), .uart_tx(uart_tx), .uart_rx(uart_rx), .leds(leds)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check16(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic io_wr(input logic [15:0] a, input logic [15:0] d);
    io_address = a; io_write_data = d; io_write_enable = 1'b1;
    @(negedge clk);
    io_write_enable = 1'b0;
  endtask

  task automatic io_rd(input logic [15:0] a, output logic [15:0] d);
    io_address = a; io_read_enable = 1'b1;
    @(negedge clk);
    io_read_enable = 1'b0;
    d = io_read_data;
  endtask

  task automatic io_rdwr(input logic [15:0] a, input logic [15:0] wd, output logic [15:0] d);
    io_address = a; io_write_data = wd; io_read_enable = 1'b1; io_write_enable = 1'b1;
    @(negedge clk);
    io_read_enable = 1'b0; io_write_enable = 1'b0;
    d = io_read_data;
  endtask

  // Expected STATUS from the model: TX side assumed drained
  function automatic logic [15:0] status_exp();
    return {12'h000, rx_ovr_model, 1'b0, (rx_model.size() != 0), 1'b1};
  endfunction

  function automatic void rx_model_push(input logic [7:0] b);
    if (rx_model.size() < DEPTH) rx_model.push_back(b);
    else rx_ovr_model = 1;
  endfunction

  // Serial frame onto uart_rx followed by two bit-times of idle
  task automatic send_rx(input logic [7:0] b, input logic stop_bit);
    uart_rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      uart_rx = b[i];
      repeat (CPB) @(negedge clk);
    end
    uart_rx = stop_bit;
    repeat (CPB) @(negedge clk);
    uart_rx = 1'b1;
    repeat (2 * CPB) @(negedge clk);
  endtask

  task automatic wait_tx_frames(input int n, input int budget);
    for (int i = 0; i < budget && tx_seen.size() < n; i++) @(negedge clk);
    check16("tx_frame_count", 16'(tx_seen.size()), 16'(n));
  endtask

  task automatic compare_tx_and_clear();
    for (int i = 0; i < tx_exp.size() && i < tx_seen.size(); i++)
      check16($sformatf("tx_byte%0d", i), {8'h00, tx_seen[i]}, {8'h00, tx_exp[i]});
    tx_seen.delete(); tx_exp.delete(); tx_start_cyc.delete();
  endtask

  // Line monitor: one frame = 40 samples, every slot of 4 samples must agree
  initial begin
    logic [39:0] s;
    logic [7:0]  b;
    bit          abort, ok;
    int          st;
    forever begin
      @(negedge clk);
      if (!resetq && uart_tx === 1'b0) begin
        s = '0; s[0] = 1'b0; abort = 0; st = cyc;
        for (int k = 1; k < 40; k++) begin
          @(negedge clk);
          if (resetq) begin abort = 1; break; end
          s[k] = uart_tx;
        end
        if (!abort) begin
          ok = (s[3:0] == 4'h0) && (s[39:36] == 4'hF);
          for (int i = 0; i < 8; i++) begin
            b[i] = s[4*(i+1)+2];
            if (s[4*(i+1) +: 4] != {4{b[i]}}) ok = 0;
          end
          if (ok) begin tx_seen.push_back(b); tx_start_cyc.push_back(st); end
          else mon_bad++;
        end
      end
    end
  end

  initial begin
    logic [15:0] rd;
    logic [7:0]  b, ledv;
    logic [7:0]  q[$];
    logic [39:0] s;
    int          lows;

    // Reset state
    repeat (3) @(negedge clk);
    check16("rst_uart_tx", 16'(uart_tx), 16'h0001);
    check16("rst_read_data", io_read_data, 16'h0000);
    check16("rst_leds", {8'h00, leds}, 16'h0000);
    resetq = 1'b0;
    @(negedge clk);
    io_rd(16'h0001, rd); check16("status_after_reset", rd, 16'h0001);

    // Register map: LED, unmapped addresses
    ledv = 8'($urandom);
    io_wr(16'h0002, {8'hEE, ledv});
    io_wr(16'h0003, 16'($urandom));
    io_rd(16'h0002, rd); check16("led_readback", rd, {8'h00, ledv});
    io_rd(16'h0003, rd); check16("unmapped_read", rd, 16'h0000);
    io_rd(16'h8002, rd); check16("unmapped_hi_read", rd, 16'h0000);

    // Simultaneous read/write of LED returns the old value
    io_wr(16'h0002, 16'h0012);
    io_rdwr(16'h0002, 16'h0034, rd); check16("led_rdwr_old", rd, 16'h0012);
    io_rd(16'h0002, rd); check16("led_rdwr_new", rd, 16'h0034);
    check16("leds_port", {8'h00, leds}, 16'h0034);

    // Exact waveform for 0x55
    io_wr(16'h0000, 16'h0055);
    tx_exp.push_back(8'h55);
    for (int i = 0; i < 20 && uart_tx !== 1'b0; i++) @(negedge clk);
    for (int k = 0; k < 40; k++) begin s[k] = uart_tx; @(negedge clk); end
    check16("tx55_start", {12'h0, s[3:0]}, 16'h0000);
    for (int i = 0; i < 8; i++)
      check16($sformatf("tx55_bit%0d", i), {12'h0, s[4*(i+1) +: 4]}, {12'h0, {4{~i[0]}}});
    check16("tx55_stop", {12'h0, s[39:36]}, 16'h000F);
    repeat (4) @(negedge clk);
    io_rd(16'h0001, rd); check16("status_after_tx55", rd, 16'h0001);
    wait_tx_frames(1, 100);
    compare_tx_and_clear();

    // Random bytes with random gaps
    for (int i = 0; i < 4; i++) begin
      b = 8'($urandom);
      io_wr(16'h0000, {8'($urandom), b});
      tx_exp.push_back(b);
      repeat ($urandom_range(0, 50)) @(negedge clk);
    end
    wait_tx_frames(4, 400);
    compare_tx_and_clear();
    repeat (50) @(negedge clk);

    // Nine back-to-back writes fill the FIFO; a tenth is dropped
    for (int i = 0; i < 9; i++) begin
      b = 8'($urandom);
      io_wr(16'h0000, {8'h00, b});
      tx_exp.push_back(b);
    end
    io_rd(16'h0001, rd); check16("status_tx_full", rd, 16'h0004);
    io_wr(16'h0000, 16'h00C3);
    io_rd(16'h0001, rd); check16("status_still_full", rd, 16'h0004);
    wait_tx_frames(9, 9 * 40 + 100);
    repeat (100) @(negedge clk);
    check16("tx_no_extra_frame", 16'(tx_seen.size()), 16'd9);
    for (int i = 1; i < 9 && i < tx_start_cyc.size(); i++)
      check16($sformatf("tx_b2b_gap%0d", i), 16'(tx_start_cyc[i] - tx_start_cyc[i-1]), 16'd40);
    compare_tx_and_clear();
    io_rd(16'h0001, rd); check16("status_tx_drained", rd, 16'h0001);

    // RX single frame 0xA3
    send_rx(8'hA3, 1'b1); rx_model_push(8'hA3);
    io_rd(16'h0001, rd); check16("status_rx_a3", rd, status_exp());
    io_rd(16'h0000, rd); check16("rx_read_a3", rd, 16'h01A3);
    void'(rx_model.pop_front());
    io_rd(16'h0000, rd); check16("rx_read_empty", rd, 16'h0000);

    // Random RX bytes
    for (int i = 0; i < 3; i++) begin
      b = 8'($urandom); send_rx(b, 1'b1); rx_model_push(b);
    end
    io_rd(16'h0001, rd); check16("status_rx_rand", rd, status_exp());
    for (int i = 0; i < 3; i++) begin
      io_rd(16'h0000, rd);
      check16($sformatf("rx_rand%0d", i), rd, {8'h01, rx_model.pop_front()});
    end

    // Framing error is discarded, a short glitch is ignored
    send_rx(8'($urandom), 1'b0);
    io_rd(16'h0001, rd); check16("status_framing_err", rd, status_exp());
    uart_rx = 1'b0; @(negedge clk); uart_rx = 1'b1;
    repeat (20) @(negedge clk);
    io_rd(16'h0001, rd); check16("status_glitch", rd, status_exp());
    io_rd(16'h0000, rd); check16("rx_after_glitch", rd, 16'h0000);

    // Nine frames with no reads: overrun, clear, then drain in order
    for (int i = 0; i < 9; i++) begin
      b = 8'($urandom); q.push_back(b); send_rx(b, 1'b1); rx_model_push(b);
    end
    io_rd(16'h0001, rd); check16("status_overrun", rd, 16'h000B);
    check16("status_overrun_model", rd, status_exp());
    io_wr(16'h0001, 16'h0001); rx_ovr_model = 0;
    io_rd(16'h0001, rd); check16("status_ovr_cleared", rd, 16'h0003);
    for (int i = 0; i < 8; i++) begin
      io_rd(16'h0000, rd);
      check16($sformatf("rx_fill%0d", i), rd, {8'h01, q[i]});
      void'(rx_model.pop_front());
    end
    io_rd(16'h0000, rd); check16("rx_fill_ninth_lost", rd, 16'h0000);
    io_rd(16'h0001, rd); check16("status_rx_drained", rd, status_exp());

    // Reset in the middle of TX bit 3
    io_wr(16'h0002, 16'h00A5);
    io_rd(16'h0002, rd);
    b = 8'($urandom) & 8'hF7;
    io_wr(16'h0000, {8'h00, b});
    for (int i = 0; i < 20 && uart_tx !== 1'b0; i++) @(negedge clk);
    repeat (17) @(negedge clk);
    check16("tx_bit3_low_before_reset", 16'(uart_tx), 16'h0000);
    #1 resetq = 1'b1;
    #1;
    check16("midreset_uart_tx", 16'(uart_tx), 16'h0001);
    check16("midreset_read_data", io_read_data, 16'h0000);
    check16("midreset_leds", {8'h00, leds}, 16'h0000);
    @(negedge clk); @(negedge clk);
    resetq = 1'b0;
    lows = 0;
    for (int i = 0; i < 80; i++) begin
      @(negedge clk);
      if (uart_tx !== 1'b1) lows++;
    end
    check16("no_frame_after_reset", 16'(lows), 16'h0000);
    check16("no_tx_bytes_after_reset", 16'(tx_seen.size()), 16'h0000);
    io_rd(16'h0001, rd); check16("status_after_midreset", rd, 16'h0001);

    check16("monitor_bad_frames", 16'(mon_bad), 16'h0000);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
